// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD controller: register bit map, FSM state
// encoding, command record and a small sizing helper.
// Optional build macro used by this slice: LCD_FIFO_EN (command FIFO).
package lcd_ctrl_pkg;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_RS_BIT   = 10;
  localparam int LCD_RW_BIT   = 9;
  localparam int LCD_DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  // One bus transfer as seen by the LCD pins.
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

  // Largest of four cycle counts, used to size the shared down-counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Pull the transfer fields out of the LSU-visible LCD register.
  function automatic lcd_cmd_t regToCmd(input logic [31:0] r);
    lcd_cmd_t c;
    c.rs   = r[LCD_RS_BIT];
    c.rw   = r[LCD_RW_BIT];
    c.data = r[LCD_DATA_LSB +: 8];
    return c;
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// LSU-side bus of the LCD controller: register value, store strobe and the
// busy/drop status returned to the core.
// Optional build macro used by this slice: LCD_FIFO_EN (command FIFO).
interface lcd_ctrl_if;
  logic [31:0] lcd_reg;
  logic        lcd_vld;
  logic        busy;
  logic        drop;

  // The LSU drives the register and strobe and observes status.
  modport master (output lcd_reg, output lcd_vld, input busy, input drop);

  // The controller consumes the register and strobe and reports status.
  modport slave (input lcd_reg, input lcd_vld, output busy, output drop);
endinterface

// File: rtl/lcd_ctrl_fifo.sv
// Small synchronous command FIFO with count-based full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
// Instantiated by lcd_ctrl only when LCD_FIFO_EN is defined.
module lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = mem_q[rdPtr_q];

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD bus sequencer driven by single LSU stores.
// Each accepted command walks SETUP -> EN_HI -> HOLD -> WAIT on one shared
// down-counter; RS/RW/DATA are latched only when a transfer starts.
// Build macro LCD_FIFO_EN: buffer commands in lcd_fifo; otherwise only one
// command is held and strobes arriving outside IDLE are dropped.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_WAIT_CYC  = 2000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_reg,
  input  logic        i_lcd_vld,
  output logic        o_LCD_ON,
  output logic        o_LCD_RS,
  output logic        o_LCD_RW,
  output logic        o_LCD_EN,
  output logic [7:0]  o_LCD_DATA,
  output logic        o_busy,
  output logic        o_drop
);

  localparam int MAX_CYC = max4(T_SETUP_CYC, T_EN_CYC, T_HOLD_CYC, T_WAIT_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(T_WAIT_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  lcd_cmd_t         cmd_q, cmd_d;
  lcd_cmd_t         inCmd, cmdNext;
  logic             en_q, en_d;
  logic             lcdOn_q, drop_q;
  logic             startCmd, dropNow, bufNonEmpty;
  logic             unused_regBits;

  assign inCmd          = regToCmd(i_lcd_reg);
  assign unused_regBits = ^{i_lcd_reg[30:11], i_lcd_reg[8]};

`ifdef LCD_FIFO_EN
  logic                         fifoPush, fifoPop, fifoFull, fifoEmpty, bypass;
  logic [$bits(lcd_cmd_t)-1:0]  fifoHead;

  // An idle controller with nothing queued takes the strobe directly.
  assign bypass      = (state_q == ST_IDLE) && fifoEmpty && i_lcd_vld;
  assign fifoPop     = !fifoEmpty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && (count_q == '0)));
  assign fifoPush    = i_lcd_vld && !bypass && (!fifoFull || fifoPop);
  assign dropNow     = i_lcd_vld && fifoFull && !fifoPop;
  assign startCmd    = bypass || fifoPop;
  assign cmdNext     = fifoPop ? lcd_cmd_t'(fifoHead) : inCmd;
  assign bufNonEmpty = !fifoEmpty;

  lcd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(lcd_cmd_t))
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (fifoPush),
    .wdata_i (inCmd),
    .pop_i   (fifoPop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );
`else
  logic unused_depth;

  assign unused_depth = (FIFO_DEPTH > 0);
  assign startCmd     = (state_q == ST_IDLE) && i_lcd_vld;
  assign dropNow      = i_lcd_vld && (state_q != ST_IDLE);
  assign cmdNext      = inCmd;
  assign bufNonEmpty  = 1'b0;
`endif

  // Next-state logic: one counter reloaded on every phase change, never below zero.
  always_comb begin
    state_d = state_q;
    count_d = (count_q != '0) ? count_q - 1'b1 : '0;
    cmd_d   = cmd_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (startCmd) begin
          state_d = ST_SETUP;
          count_d = LD_SETUP;
          cmd_d   = cmdNext;
        end
      end
      ST_SETUP: begin
        if (count_q == '0) begin
          state_d = ST_EN_HI;
          count_d = LD_EN;
          en_d    = 1'b1;
        end
      end
      ST_EN_HI: begin
        if (count_q == '0) begin
          state_d = ST_HOLD;
          count_d = LD_HOLD;
          en_d    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (count_q == '0) begin
          state_d = ST_WAIT;
          count_d = LD_WAIT;
        end
      end
      ST_WAIT: begin
        if (count_q == '0) begin
          if (startCmd) begin
            state_d = ST_SETUP;
            count_d = LD_SETUP;
            cmd_d   = cmdNext;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  // Sequencer registers plus registered backlight and drop pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      cmd_q   <= '0;
      en_q    <= 1'b0;
      lcdOn_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cmd_q   <= cmd_d;
      en_q    <= en_d;
      lcdOn_q <= i_lcd_reg[LCD_ON_BIT];
      drop_q  <= dropNow;
    end
  end

  assign o_LCD_ON   = lcdOn_q;
  assign o_LCD_RS   = cmd_q.rs;
  assign o_LCD_RW   = cmd_q.rw;
  assign o_LCD_DATA = cmd_q.data;
  assign o_LCD_EN   = en_q;
  assign o_busy     = (state_q != ST_IDLE) || bufNonEmpty;
  assign o_drop     = drop_q;

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_SETUP_CYC, default 4: cycles RS/RW/DATA are stable before EN rises.
REQ-002 Parameter T_EN_CYC, default 12: cycles EN is held high.
REQ-003 Parameter T_HOLD_CYC, default 4: cycles RS/RW/DATA are held after EN falls.
REQ-004 Parameter T_WAIT_CYC, default 2000: idle gap after hold, covering LCD command execution time.
REQ-005 Parameter FIFO_DEPTH, default 4, power of two >= 2: command buffer depth, used only with LCD_FIFO_EN.
REQ-006 One clock; reset is asynchronous and active-low: i_clk, i_rst_n.
REQ-007 Ports, listed as name, direction, width, meaning:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, async active-low reset.
- i_lcd_reg, in, 32, LSU LCD register; [31]=ON, [10]=RS, [9]=RW, [7:0]=DATA.
- i_lcd_vld, in, 1, one-cycle LSU store strobe to the LCD register.
- o_LCD_ON, out, 1, backlight/power.
- o_LCD_RS, out, 1, register select.
- o_LCD_RW, out, 1, read/write select.
- o_LCD_EN, out, 1, enable strobe.
- o_LCD_DATA, out, 8, data bus.
- o_busy, out, 1, high while a transfer is active or buffered.
- o_drop, out, 1, one-cycle pulse when an accepted strobe is lost.

Function
REQ-008 o_LCD_ON SHALL follow i_lcd_reg[31] registered, one cycle latency, regardless of FSM state.
REQ-009 The FSM states SHALL be IDLE, SETUP, EN_HI, HOLD, WAIT, driven by a single down-counter sized for the largest T_*_CYC.
- IDLE to SETUP: a command is available; latch {RS,RW,DATA}; load T_SETUP_CYC-1.
- SETUP to EN_HI: on count 0; EN=1.
- EN_HI to HOLD: after T_EN_CYC cycles; EN=0.
- HOLD to WAIT: after T_HOLD_CYC cycles.
- WAIT to IDLE: after T_WAIT_CYC cycles.
REQ-010 o_LCD_EN SHALL be high only in EN_HI and SHALL be registered, with no glitches.
REQ-011 RS/RW/DATA outputs SHALL change only on the IDLE-to-SETUP transition.
REQ-012 Without a new command, the FSM SHALL stay in IDLE.
REQ-013 Back-to-back commands SHALL start from WAIT-to-IDLE with zero extra cycles: WAIT goes directly to SETUP when a command is pending.
REQ-014 o_busy SHALL be (state != IDLE) OR (buffer non-empty).
REQ-015 A strobe in IDLE with an empty buffer SHALL reach SETUP on the next clock, one cycle latency.
REQ-016 o_drop SHALL pulse in the cycle after a strobe arrives while no storage is free.
REQ-017 A dropped strobe SHALL leave the FSM and the buffer unchanged.
REQ-018 Counter arithmetic SHALL be unsigned and SHALL never wrap below 0.

Reset
REQ-019 While i_rst_n is low, the block SHALL hold: state=IDLE, counter=0, all LCD outputs=0, o_busy=0, o_drop=0, buffer empty.
REQ-020 Reset asserted mid-transfer SHALL force EN low immediately and discard pending commands.

Configuration
REQ-021 With macro LCD_FIFO_EN defined:
- Strobes SHALL push {RS,RW,DATA} into a FIFO_DEPTH FIFO; the FSM pops on IDLE/WAIT exit.
- Push and pop in the same cycle SHALL both be honoured when full.
- o_drop SHALL fire only when the FIFO is full and no pop occurs.
REQ-022 With LCD_FIFO_EN undefined:
- A single holding register SHALL be used, with no pending slot.
- Any strobe while state != IDLE SHALL be dropped.

Structure
REQ-023 The shared package SHALL hold the lcd_state_e typedef and the bit-position constants LCD_ON_BIT=31, LCD_RS_BIT=10, LCD_RW_BIT=9, LCD_DATA_LSB=0.
REQ-024 The FIFO SHALL be the sub-module lcd_fifo (synchronous, count-based full/empty), instantiated only under LCD_FIFO_EN.

Verification
REQ-025 A single strobe with i_lcd_reg=0x8000_0438 SHALL produce:
- LCD_RS=1 and DATA=0x38 at the next cycle.
- EN high for exactly 12 cycles, starting 4 cycles after SETUP entry.
- o_busy low again after 4+12+4+2000 cycles.
REQ-026 A strobe with [31]=0 during a transfer SHALL drop LCD_ON after one cycle while the EN sequence continues unchanged.
REQ-027 Five strobes on consecutive cycles from IDLE:
- With FIFO: 0 drops and 5 EN pulses in order.
- Without FIFO: 4 drops and 1 EN pulse.
REQ-028 A strobe coinciding with the final WAIT cycle, FIFO empty: SETUP SHALL be entered two cycles later with no drop.
REQ-029 Asserting i_rst_n=0 during EN_HI SHALL make EN=0 asynchronously; after release, o_busy=0 and no pulse occurs.
REQ-030 FIFO full, with a strobe in the same cycle as a pop: no drop, and the count stays at FIFO_DEPTH.
